uart_cmd_master: RTL and testbench
==================================

# uart_cmd_master

Host-side command initiator for the UART register/ALU command protocol. It takes one parallel command request, serializes it into the command byte frame (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands) toward the UART transmitter, and collects the response bytes from the UART receiver. It then returns either an assembled result or a timeout indication. It sits in the test-host/bridge side of the system, between a local requester and the UART TX/RX pair.

## Interface
- DATA_WIDTH, 8, UART byte width
- ALU_O_WIDTH, 16, response/result width (two bytes)
- TIMEOUT_CYCLES, 1024, max idle clk cycles between response bytes; counter width $clog2(TIMEOUT_CYCLES)

- clk  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- CMD_VLD  in  1  command request strobe
- CMD_OP  in  2  0 = write, 1 = read, 2 = ALU with operands, 3 = ALU without operands
- CMD_ADDR  in  4  register file address
- CMD_DATA  in  DATA_WIDTH  write data
- CMD_OP_A, CMD_OP_B  in  DATA_WIDTH  ALU operands
- CMD_FUN  in  4  ALU function code
- CMD_BUSY  out  1  high whenever the FSM is not in IDLE
- TX_P_DATA  out  DATA_WIDTH  byte to UART TX
- TX_D_VLD  out  1  byte valid; held with stable data until accepted
- TX_BUSY  in  1  UART TX busy; byte accepted in a cycle with TX_D_VLD=1 and TX_BUSY=0
- RX_P_DATA  in  DATA_WIDTH  byte from UART RX
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RSP_DATA  out  ALU_O_WIDTH  result, held until the next completion
- RSP_VLD  out  1  one-cycle completion pulse
- RSP_TIMEOUT  out  1  one-cycle timeout pulse

## Operation
- Accept: CMD_VLD=1 while in IDLE. All CMD_* fields are captured into registers. CMD_VLD outside IDLE is ignored, with no queuing.
- Frames (byte order):
  - write: AA, {4'b0,ADDR}, DATA; no response.
  - read: BB, {4'b0,ADDR}; 1 response byte.
  - ALU with operands: CC, A, B, {4'b0,FUN}; 2 response bytes.
  - ALU without operands: DD, {4'b0,FUN}; 2 response bytes.
- States:
  - IDLE → SEND on accept.
  - SEND → WAIT_RSP after the last byte is accepted (read/ALU).
  - SEND → IDLE after the last byte is accepted (write), with RSP_VLD pulse and RSP_DATA=0.
  - WAIT_RSP → IDLE on the final response byte (RSP_VLD) or on timeout (RSP_TIMEOUT).
- SEND uses a 2-bit byte index and a frame length decoded from the captured opcode.
- Response assembly:
  - read: RSP_DATA = {8'h00, byte0}.
  - ALU: first byte = RSP_DATA[7:0], second byte = RSP_DATA[15:8].
- RX_D_VLD outside WAIT_RSP is ignored.
- Timeout counter:
  - Cleared on entry to WAIT_RSP and on every received byte; increments each WAIT_RSP cycle.
  - Reaching TIMEOUT_CYCLES-1 with no RX_D_VLD that cycle produces RSP_TIMEOUT.
  - RSP_DATA is left unchanged (no partial update committed) on timeout.
  - An RX_D_VLD in the terminal-count cycle wins over the timeout.
- Reset (any time, including mid-frame or mid-wait):
  - Return to IDLE.
  - All outputs 0: CMD_BUSY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT.
  - Counters and captured fields are cleared.

## Timing
- All outputs except CMD_BUSY are registered. CMD_BUSY is decoded from the state register.
- Accept at edge k → cycle k+1: CMD_BUSY=1, TX_D_VLD=1, TX_P_DATA=header.
- Byte accepted in cycle n → next byte on TX_P_DATA in cycle n+1, TX_D_VLD remains 1 (back-to-back when TX_BUSY=0).
- Last byte accepted in cycle n → TX_D_VLD=0 in cycle n+1.
  - Write: RSP_VLD=1 in n+1, state IDLE in n+1.
  - Otherwise: WAIT_RSP in n+1.
- Minimum write latency with TX_BUSY=0: accept at k, RSP_VLD in cycle k+4.
- Final RX byte in cycle m → RSP_VLD=1 and RSP_DATA valid in m+1, CMD_BUSY=0 in m+1. A new CMD_VLD in m+1 is accepted.
- Timeout: terminal count in cycle t → RSP_TIMEOUT=1 and IDLE in t+1.
- RSP_VLD and RSP_TIMEOUT are never high together.

## Test plan
- Write, ADDR=5, DATA=0x3C, TX_BUSY=0 → TX bytes AA,05,3C in consecutive cycles; RSP_VLD in the cycle after 0x3C with RSP_DATA=0x0000; CMD_BUSY low in that same cycle.
- Read, ADDR=2, TX_BUSY high 3 cycles per byte, RX returns 0x5A → TX bytes BB,02, each held stable while busy; RSP_DATA=0x005A, single-cycle RSP_VLD.
- ALU with operands, A=0x10, B=0x20, FUN=0 → TX bytes CC,10,20,00; RX 0x30 then 0x00 → RSP_DATA=0x0030. ALU without operands, FUN=2, RX 0x00,0x02 → TX bytes DD,02; RSP_DATA=0x0200.
- Timeout, TIMEOUT_CYCLES=16: read with no RX → RSP_TIMEOUT exactly 16 cycles after WAIT_RSP entry, RSP_DATA unchanged. ALU with one byte received → timer restarts at that byte. RX byte in the terminal-count cycle → no timeout.
- Collisions: CMD_VLD while busy ignored (frame bytes unchanged); stray RX_D_VLD in IDLE/SEND ignored; new command accepted in the RSP_VLD cycle starts its header the next cycle.
- Reset asserted mid-SEND and mid-WAIT_RSP → all outputs 0 immediately (async); after release, IDLE and a fresh read completes correctly.

Source files
------------

// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - serializes one command into a UART byte frame and collects the response
module uart_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ALU_O_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   CMD_VLD,
  input  logic [1:0]             CMD_OP,
  input  logic [3:0]             CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]  CMD_DATA,
  input  logic [DATA_WIDTH-1:0]  CMD_OP_A,
  input  logic [DATA_WIDTH-1:0]  CMD_OP_B,
  input  logic [3:0]             CMD_FUN,
  output logic                   CMD_BUSY,
  output logic [DATA_WIDTH-1:0]  TX_P_DATA,
  output logic                   TX_D_VLD,
  input  logic                   TX_BUSY,
  input  logic [DATA_WIDTH-1:0]  RX_P_DATA,
  input  logic                   RX_D_VLD,
  output logic [ALU_O_WIDTH-1:0] RSP_DATA,
  output logic                   RSP_VLD,
  output logic                   RSP_TIMEOUT
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_ALU = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [3:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic [3:0]             fun_q, fun_d;
  logic [1:0]             idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_vld_q, tx_vld_d;
  logic [ALU_O_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_vld_q, rsp_vld_d;
  logic                   rsp_to_q, rsp_to_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   rx_cnt_q, rx_cnt_d;
  logic [DATA_WIDTH-1:0]  rx_byte0_q, rx_byte0_d;

  // Byte at position idx of the frame for the given opcode
  function automatic logic [DATA_WIDTH-1:0] frame_byte(
    input logic [1:0]            op,
    input logic [1:0]            idx,
    input logic [3:0]            addr,
    input logic [DATA_WIDTH-1:0] data,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [3:0]            fun
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_WR: begin
        case (idx)
          2'd0:    r = DATA_WIDTH'(8'hAA);
          2'd1:    r = DATA_WIDTH'(addr);
          default: r = data;
        endcase
      end
      OP_RD:  r = (idx == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(addr);
      OP_ALU: begin
        case (idx)
          2'd0:    r = DATA_WIDTH'(8'hCC);
          2'd1:    r = a;
          2'd2:    r = b;
          default: r = DATA_WIDTH'(fun);
        endcase
      end
      default: r = (idx == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(fun);
    endcase
    return r;
  endfunction

  // Index of the final byte of each frame
  function automatic logic [1:0] frame_last(input logic [1:0] op);
    case (op)
      OP_WR:   return 2'd2;
      OP_ALU:  return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  assign CMD_BUSY    = (state_q != S_IDLE);
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_VLD     = rsp_vld_q;
  assign RSP_TIMEOUT = rsp_to_q;

  // State and all registered outputs; reset clears everything at once
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_to_q   <= 1'b0;
      tmo_q      <= '0;
      rx_cnt_q   <= 1'b0;
      rx_byte0_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_to_q   <= rsp_to_d;
      tmo_q      <= tmo_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_byte0_q <= rx_byte0_d;
    end
  end

  // Next-state: capture, frame send, response collection and timeout
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = tx_vld_q;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = 1'b0;
    rsp_to_d   = 1'b0;
    tmo_d      = tmo_q;
    rx_cnt_d   = rx_cnt_q;
    rx_byte0_d = rx_byte0_q;

    case (state_q)
      S_IDLE: begin
        if (CMD_VLD) begin
          op_d      = CMD_OP;
          addr_d    = CMD_ADDR;
          data_d    = CMD_DATA;
          a_d       = CMD_OP_A;
          b_d       = CMD_OP_B;
          fun_d     = CMD_FUN;
          idx_d     = 2'd0;
          tx_data_d = frame_byte(CMD_OP, 2'd0, CMD_ADDR, CMD_DATA, CMD_OP_A, CMD_OP_B, CMD_FUN);
          tx_vld_d  = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_vld_q && !TX_BUSY) begin
          if (idx_q == frame_last(op_q)) begin
            tx_vld_d = 1'b0;
            if (op_q == OP_WR) begin
              state_d    = S_IDLE;
              rsp_vld_d  = 1'b1;
              rsp_data_d = '0;
            end else begin
              state_d  = S_WAIT;
              tmo_d    = '0;
              rx_cnt_d = 1'b0;
            end
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = frame_byte(op_q, idx_q + 2'd1, addr_q, data_q, a_q, b_q, fun_q);
          end
        end
      end
      S_WAIT: begin
        if (RX_D_VLD) begin
          tmo_d = '0;
          if (op_q == OP_RD) begin
            state_d    = S_IDLE;
            rsp_vld_d  = 1'b1;
            rsp_data_d = ALU_O_WIDTH'(RX_P_DATA);
          end else if (rx_cnt_q) begin
            state_d    = S_IDLE;
            rsp_vld_d  = 1'b1;
            rsp_data_d = ALU_O_WIDTH'({RX_P_DATA, rx_byte0_q});
          end else begin
            rx_cnt_d   = 1'b1;
            rx_byte0_d = RX_P_DATA;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = S_IDLE;
          rsp_to_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb/tb_uart_cmd_master.sv - directed and randomized checks of uart_cmd_master against a frame/response model
module tb_uart_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VLD = 1'b0;
  logic [1:0]  CMD_OP = '0;
  logic [3:0]  CMD_ADDR = '0;
  logic [7:0]  CMD_DATA = '0;
  logic [7:0]  CMD_OP_A = '0;
  logic [7:0]  CMD_OP_B = '0;
  logic [3:0]  CMD_FUN = '0;
  logic        CMD_BUSY;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_TIMEOUT;

  int          vec = 0;
  int          miss = 0;
  logic [15:0] last_rsp = '0;
  logic [7:0]  exp_q[$];

  uart_cmd_master #(
    .DATA_WIDTH    (8),
    .ALU_O_WIDTH   (16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .CMD_VLD    (CMD_VLD),
    .CMD_OP     (CMD_OP),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_DATA   (CMD_DATA),
    .CMD_OP_A   (CMD_OP_A),
    .CMD_OP_B   (CMD_OP_B),
    .CMD_FUN    (CMD_FUN),
    .CMD_BUSY   (CMD_BUSY),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .TX_BUSY    (TX_BUSY),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RSP_DATA   (RSP_DATA),
    .RSP_VLD    (RSP_VLD),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic no_pulse(input string tag);
    chk({tag, "_rsp_vld"}, 16'(RSP_VLD), 16'd0);
    chk({tag, "_rsp_to"}, 16'(RSP_TIMEOUT), 16'd0);
  endtask

  task automatic stray_on();
    CMD_VLD   = 1'b1;
    CMD_OP    = 2'($urandom);
    CMD_ADDR  = 4'($urandom);
    CMD_DATA  = 8'($urandom);
    CMD_OP_A  = 8'($urandom);
    CMD_OP_B  = 8'($urandom);
    CMD_FUN   = 4'($urandom);
    RX_D_VLD  = 1'b1;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic stray_off();
    CMD_VLD  = 1'b0;
    RX_D_VLD = 1'b0;
  endtask

  // One complete command: issue, check every frame byte, feed nprov response bytes, check outcome
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                        input int busy, input int nprov, input int gap0, input int gap1,
                        input logic [7:0] r0, input logic [7:0] r1, input bit stray);
    int          nb;
    int          g;
    logic [15:0] exp_rsp;
    exp_q.delete();
    case (op)
      2'd0: begin exp_q.push_back(8'hAA); exp_q.push_back({4'h0, addr}); exp_q.push_back(data); nb = 0; end
      2'd1: begin exp_q.push_back(8'hBB); exp_q.push_back({4'h0, addr}); nb = 1; end
      2'd2: begin exp_q.push_back(8'hCC); exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back({4'h0, fun}); nb = 2; end
      default: begin exp_q.push_back(8'hDD); exp_q.push_back({4'h0, fun}); nb = 2; end
    endcase
    exp_rsp = (nb == 1) ? {8'h00, r0} : {r1, r0};

    if (stray) begin
      RX_D_VLD  = 1'b1;
      RX_P_DATA = 8'($urandom);
      step();
      RX_D_VLD = 1'b0;
      chk("idle_stray_busy", 16'(CMD_BUSY), 16'd0);
      no_pulse("idle_stray");
    end

    chk("pre_cmd_busy", 16'(CMD_BUSY), 16'd0);
    CMD_VLD = 1'b1; CMD_OP = op; CMD_ADDR = addr; CMD_DATA = data;
    CMD_OP_A = a; CMD_OP_B = b; CMD_FUN = fun;
    step();
    CMD_VLD = 1'b0;
    chk("accept_busy", 16'(CMD_BUSY), 16'd1);
    no_pulse("accept");

    foreach (exp_q[j]) begin
      for (int c = 0; c < busy; c++) begin
        TX_BUSY = 1'b1;
        chk("tx_hold_vld", 16'(TX_D_VLD), 16'd1);
        chk("tx_hold_data", 16'(TX_P_DATA), 16'(exp_q[j]));
        if (stray) stray_on();
        step();
        stray_off();
      end
      TX_BUSY = 1'b0;
      chk("tx_vld", 16'(TX_D_VLD), 16'd1);
      chk("tx_data", 16'(TX_P_DATA), 16'(exp_q[j]));
      chk("send_busy", 16'(CMD_BUSY), 16'd1);
      if (stray) stray_on();
      step();
      stray_off();
    end
    chk("tx_done_vld", 16'(TX_D_VLD), 16'd0);

    if (nb == 0) begin
      chk("wr_rsp_vld", 16'(RSP_VLD), 16'd1);
      chk("wr_rsp_to", 16'(RSP_TIMEOUT), 16'd0);
      chk("wr_rsp_data", RSP_DATA, 16'h0000);
      chk("wr_busy", 16'(CMD_BUSY), 16'd0);
      last_rsp = 16'h0000;
      return;
    end

    for (int i = 0; i < nprov; i++) begin
      g = (i == 0) ? gap0 : gap1;
      for (int c = 0; c < g; c++) begin
        no_pulse("wait_gap");
        chk("wait_busy", 16'(CMD_BUSY), 16'd1);
        if (stray) begin
          CMD_VLD = 1'b1;
          CMD_OP  = 2'($urandom);
        end
        step();
        CMD_VLD = 1'b0;
      end
      no_pulse("wait_rx");
      RX_D_VLD  = 1'b1;
      RX_P_DATA = (i == 0) ? r0 : r1;
      step();
      RX_D_VLD = 1'b0;
    end

    if (nprov >= nb) begin
      chk("rsp_vld", 16'(RSP_VLD), 16'd1);
      chk("rsp_to_low", 16'(RSP_TIMEOUT), 16'd0);
      chk("rsp_data", RSP_DATA, exp_rsp);
      chk("rsp_busy", 16'(CMD_BUSY), 16'd0);
      last_rsp = exp_rsp;
    end else begin
      for (int c = 0; c < TO; c++) begin
        no_pulse("tmo_run");
        chk("tmo_busy", 16'(CMD_BUSY), 16'd1);
        step();
      end
      chk("tmo_pulse", 16'(RSP_TIMEOUT), 16'd1);
      chk("tmo_rsp_vld", 16'(RSP_VLD), 16'd0);
      chk("tmo_rsp_data", RSP_DATA, last_rsp);
      chk("tmo_busy_low", 16'(CMD_BUSY), 16'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 16'(CMD_BUSY), 16'd0);
    chk({tag, "_tx_data"}, 16'(TX_P_DATA), 16'd0);
    chk({tag, "_tx_vld"}, 16'(TX_D_VLD), 16'd0);
    chk({tag, "_rsp_data"}, RSP_DATA, 16'd0);
    chk({tag, "_rsp_vld"}, 16'(RSP_VLD), 16'd0);
    chk({tag, "_rsp_to"}, 16'(RSP_TIMEOUT), 16'd0);
  endtask

  initial begin
    logic [1:0] rop;
    int         rnb;
    int         rprov;

    step();
    step();
    chk_all_zero("reset");
    RST = 1'b1;
    step();

    do_cmd(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0);
    do_cmd(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'd0, 3, 1, 2, 0, 8'h5A, 8'h00, 1'b0);
    do_cmd(2'd2, 4'd0, 8'h00, 8'h10, 8'h20, 4'd0, 0, 2, 1, 3, 8'h30, 8'h00, 1'b0);
    do_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd2, 1, 2, 0, 0, 8'h00, 8'h02, 1'b0);
    do_cmd(2'd1, 4'd9, 8'h00, 8'h00, 8'h00, 4'd0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0);
    do_cmd(2'd2, 4'd0, 8'h00, 8'h11, 8'h22, 4'd3, 0, 1, 10, 0, 8'h77, 8'h00, 1'b0);
    do_cmd(2'd1, 4'd4, 8'h00, 8'h00, 8'h00, 4'd0, 0, 1, TO - 1, 0, 8'hE1, 8'h00, 1'b0);
    do_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd7, 0, 2, TO - 1, TO - 1, 8'h34, 8'h12, 1'b1);
    do_cmd(2'd0, 4'd1, 8'h99, 8'h00, 8'h00, 4'd0, 2, 0, 0, 0, 8'h00, 8'h00, 1'b1);
    do_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd5, 0, 2, 0, 0, 8'hCD, 8'hAB, 1'b0);

    CMD_VLD = 1'b1; CMD_OP = 2'd1; CMD_ADDR = 4'd7;
    step();
    CMD_VLD = 1'b0;
    TX_BUSY = 1'b1;
    step();
    chk("mid_send_vld", 16'(TX_D_VLD), 16'd1);
    RST = 1'b0;
    #1;
    chk_all_zero("rst_send");
    step();
    RST = 1'b1;
    TX_BUSY = 1'b0;
    step();
    chk_all_zero("post_rst_send");

    do_cmd(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd6, 0, 2, 0, 0, 8'h66, 8'h55, 1'b0);
    CMD_VLD = 1'b1; CMD_OP = 2'd3; CMD_FUN = 4'd1;
    step();
    CMD_VLD = 1'b0;
    step();
    step();
    step();
    chk("mid_wait_busy", 16'(CMD_BUSY), 16'd1);
    RST = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    last_rsp = 16'h0000;
    step();
    RST = 1'b1;
    step();
    do_cmd(2'd1, 4'd3, 8'h00, 8'h00, 8'h00, 4'd0, 1, 1, 4, 0, 8'hA5, 8'h00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rop   = 2'($urandom_range(0, 3));
      rnb   = (rop == 2'd0) ? 0 : ((rop == 2'd1) ? 1 : 2);
      rprov = (rnb > 0 && $urandom_range(0, 4) == 0) ? rnb - 1 : rnb;
      do_cmd(rop, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
             $urandom_range(0, 3), rprov, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
             8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    step();
    no_pulse("final");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
